// File: rtl/knight_anim_pkg.sv
// Shared types for the knight sprite sequencer: states, sprite IDs, status codes, hold counts.
// KNIGHT_LAND_ANIM_EN adds the LAND state; no latency or backpressure applies to a package.
package knight_anim_pkg;

  localparam int unsigned WALK_HOLD = 6;
  localparam int unsigned FALL_HOLD = 16;
  localparam int unsigned LAND_HOLD = 4;
  localparam logic [15:0] SPRITE_WORDS = 16'd3200;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WALK = 3'd1,
    S_JUMP = 3'd2,
`ifdef KNIGHT_LAND_ANIM_EN
    S_FALL = 3'd3,
    S_LAND = 3'd4
`else
    S_FALL = 3'd3
`endif
  } anim_state_t;

  localparam logic [2:0] SPR_IDLE  = 3'd0;
  localparam logic [2:0] SPR_WALK1 = 3'd1;
  localparam logic [2:0] SPR_WALK2 = 3'd2;
  localparam logic [2:0] SPR_WALK3 = 3'd3;
  localparam logic [2:0] SPR_JUMP  = 3'd4;
  localparam logic [2:0] SPR_FALL  = 3'd5;
  localparam logic [2:0] SPR_FALL1 = 3'd6;
  localparam logic [2:0] SPR_LAND  = 3'd7;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_WALK = 4'd1;
  localparam logic [3:0] ST_JUMP = 4'd2;
  localparam logic [3:0] ST_FALL = 4'd3;

  // Unknown status codes (4..15) fall back to idle.
  function automatic anim_state_t status_to_state(input logic [3:0] st);
    case (st)
      ST_WALK: return S_WALK;
      ST_JUMP: return S_JUMP;
      ST_FALL: return S_FALL;
      default: return S_IDLE;
    endcase
  endfunction

  // The 50-px hit box belongs to the upright poses.
  function automatic logic sprite_wide(input logic [2:0] id);
    return (id == SPR_IDLE) || (id == SPR_WALK1) || (id == SPR_WALK2) ||
           (id == SPR_WALK3) || (id == SPR_LAND);
  endfunction

endpackage

// File: rtl/knight_anim_sequencer_frame_tick_sync.sv
// frame_clk synchroniser + rising-edge detect; tick is one Clk wide, 3 Clk after the edge.
// No backpressure; flops reset high so a frame_clk held high through reset yields no tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync2_q, prev_q, tick_q;
  logic tick_d;

  always_comb begin
    tick_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/knight_anim_sequencer.sv
// Knight sprite frame/mirror sequencer; outputs update 1 Clk after each frame tick, held until the next.
// No backpressure. Define KNIGHT_LAND_ANIM_EN to add the landing frame after a fall.
module knight_anim_sequencer
  import knight_anim_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [3:0]  Player_Status,
  input  logic        Inverse,
  output logic [2:0]  Sprite_ID,
  output logic        Sprite_Mirror,
  output logic [15:0] Sprite_Base,
  output logic        Sprite_Wide,
  output logic        Frame_Start
);

  logic        tick;
  anim_state_t state_q, state_d, req_state, nxt_state;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  sprite_id_q, sprite_id_d;
  logic        mirror_q, mirror_d;
  logic [15:0] base_q, base_d;
  logic        wide_q, wide_d;
  logic        frame_start_q;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sprite_id_d = sprite_id_q;
    mirror_d    = mirror_q;
    base_d      = base_q;
    wide_d      = wide_q;

    req_state = status_to_state(Player_Status);
    nxt_state = req_state;
`ifdef KNIGHT_LAND_ANIM_EN
    // Leaving a fall always lands first; jump/fall requests cut the landing short.
    if (state_q == S_FALL && req_state != S_FALL) begin
      nxt_state = S_LAND;
    end else if (state_q == S_LAND && req_state != S_JUMP && req_state != S_FALL &&
                 cnt_q != 8'(LAND_HOLD - 1)) begin
      nxt_state = S_LAND;
    end
`endif

    if (tick) begin
      state_d  = nxt_state;
      mirror_d = Inverse;
      if (nxt_state != state_q) begin
        cnt_d = 8'd0;
        idx_d = 2'd0;
      end else begin
        case (state_q)
          S_WALK: begin
            if (cnt_q == 8'(WALK_HOLD - 1)) begin
              cnt_d = 8'd0;
              idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_FALL: begin
            if (cnt_q == 8'(FALL_HOLD - 1)) begin
              cnt_d = 8'd0;
              idx_d = {1'b0, ~idx_q[0]};
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
`ifdef KNIGHT_LAND_ANIM_EN
          S_LAND: cnt_d = cnt_q + 8'd1;
`endif
          default: begin
            cnt_d = 8'd0;
            idx_d = 2'd0;
          end
        endcase
      end

      case (state_d)
        S_WALK:  sprite_id_d = SPR_WALK1 + {1'b0, idx_d};
        S_JUMP:  sprite_id_d = SPR_JUMP;
        S_FALL:  sprite_id_d = idx_d[0] ? SPR_FALL1 : SPR_FALL;
`ifdef KNIGHT_LAND_ANIM_EN
        S_LAND:  sprite_id_d = SPR_LAND;
`endif
        default: sprite_id_d = SPR_IDLE;
      endcase
      base_d = 16'(sprite_id_d) * SPRITE_WORDS;
      wide_d = sprite_wide(sprite_id_d);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      idx_q         <= 2'd0;
      sprite_id_q   <= SPR_IDLE;
      mirror_q      <= 1'b0;
      base_q        <= 16'd0;
      wide_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      sprite_id_q   <= sprite_id_d;
      mirror_q      <= mirror_d;
      base_q        <= base_d;
      wide_q        <= wide_d;
      frame_start_q <= tick;
    end
  end

  assign Sprite_ID     = sprite_id_q;
  assign Sprite_Mirror = mirror_q;
  assign Sprite_Base   = base_q;
  assign Sprite_Wide   = wide_q;
  assign Frame_Start   = frame_start_q;

endmodule

// File: tb/tb_knight_anim_sequencer.sv
// Directed bench for knight_anim_sequencer; expected sprite sequences are hand-derived.
module tb_knight_anim_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [3:0]  Player_Status;
  logic        Inverse;
  logic [2:0]  Sprite_ID;
  logic        Sprite_Mirror;
  logic [15:0] Sprite_Base;
  logic        Sprite_Wide;
  logic        Frame_Start;

  int n_vec = 0;
  int n_err = 0;

  knight_anim_sequencer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .Player_Status (Player_Status),
    .Inverse       (Inverse),
    .Sprite_ID     (Sprite_ID),
    .Sprite_Mirror (Sprite_Mirror),
    .Sprite_Base   (Sprite_Base),
    .Sprite_Wide   (Sprite_Wide),
    .Frame_Start   (Frame_Start)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_id"},   32'(Sprite_ID), 0);
    chk({tag, "_base"}, 32'(Sprite_Base), 0);
    chk({tag, "_wide"}, 32'(Sprite_Wide), 1);
    chk({tag, "_mir"},  32'(Sprite_Mirror), 0);
    chk({tag, "_fs"},   32'(Frame_Start), 0);
  endtask

  // One frame_clk pulse; outputs are checked the cycle the tick's update lands.
  task automatic do_tick(input logic [2:0] exp_id, input logic exp_mir, input string tag);
    logic [15:0] exp_base;
    logic        exp_wide;
    exp_base = 16'(exp_id) * 16'd3200;
    exp_wide = (exp_id == 3'd0) || (exp_id == 3'd1) || (exp_id == 3'd2) ||
               (exp_id == 3'd3) || (exp_id == 3'd7);
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 chk({tag, "_fs_early"}, 32'(Frame_Start), 0);
    @(posedge Clk);
    #1;
    chk({tag, "_fs"},   32'(Frame_Start), 1);
    chk({tag, "_id"},   32'(Sprite_ID), 32'(exp_id));
    chk({tag, "_base"}, 32'(Sprite_Base), 32'(exp_base));
    chk({tag, "_wide"}, 32'(Sprite_Wide), 32'(exp_wide));
    chk({tag, "_mir"},  32'(Sprite_Mirror), 32'(exp_mir));
    @(posedge Clk);
    #1 chk({tag, "_fs_end"}, 32'(Frame_Start), 0);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_count;
    logic [2:0] e;

    // Reset with frame_clk held high, then idle for 100 cycles.
    Reset = 1'b1;
    frame_clk = 1'b1;
    Player_Status = 4'd0;
    Inverse = 1'b0;
    repeat (5) @(negedge Clk);
    chk_reset_vals("reset");
    Reset = 1'b0;
    fs_count = 0;
    repeat (100) begin
      @(negedge Clk);
      if (Frame_Start) fs_count++;
    end
    chk("no_spurious_tick", 32'(fs_count), 0);
    chk("idle_id", 32'(Sprite_ID), 0);
    chk("idle_base", 32'(Sprite_Base), 0);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);

    // Walk cycle: 1 x6, 2 x6, 3 x6, 1 x2.
    Player_Status = 4'd1;
    for (int i = 0; i < 20; i++) begin
      e = (i < 6) ? 3'd1 : (i < 12) ? 3'd2 : (i < 18) ? 3'd3 : 3'd1;
      do_tick(e, 1'b0, "walk");
    end

    // Fall cycle: 5 x16, 6 x16, 5 x8, then straight back to walk1.
    Player_Status = 4'd3;
    for (int i = 0; i < 40; i++) begin
      e = (i < 16) ? 3'd5 : (i < 32) ? 3'd6 : 3'd5;
      do_tick(e, 1'b0, "fall");
    end
    Player_Status = 4'd1;
    do_tick(3'd1, 1'b0, "fall_to_walk");

    // Reach walk idx 1, then flip Inverse between ticks with a status glitch.
    for (int i = 0; i < 5; i++) do_tick(3'd1, 1'b0, "walk_b");
    do_tick(3'd2, 1'b0, "walk_idx1");
    Inverse = 1'b1;
    Player_Status = 4'd0;
    repeat (2) @(negedge Clk);
    Inverse = 1'b0;
    Player_Status = 4'd1;
    repeat (2) @(negedge Clk);
    Inverse = 1'b1;
    for (int i = 0; i < 5; i++) do_tick(3'd2, 1'b1, "mirror_walk2");
    do_tick(3'd3, 1'b1, "mirror_walk3");

    // Reset lands in the same cycle as a tick while at walk idx 2.
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1 chk_reset_vals("reset_on_tick");
    @(negedge Clk);
    Reset = 1'b0;
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    do_tick(3'd1, 1'b1, "after_reset_walk1");

    // Fall then idle, with and without the landing frame.
    Player_Status = 4'd3;
    do_tick(3'd5, 1'b1, "land_fall");
    Player_Status = 4'd0;
`ifdef KNIGHT_LAND_ANIM_EN
    for (int i = 0; i < 4; i++) do_tick(3'd7, 1'b1, "land_hold");
`endif
    do_tick(3'd0, 1'b1, "land_idle");
    Player_Status = 4'd3;
    do_tick(3'd5, 1'b1, "land_fall2");
    Player_Status = 4'd0;
`ifdef KNIGHT_LAND_ANIM_EN
    do_tick(3'd7, 1'b1, "land_first");
`else
    do_tick(3'd0, 1'b1, "land_first");
`endif
    Player_Status = 4'd2;
    do_tick(3'd4, 1'b1, "land_abort_jump");

    // Out-of-range status decodes as idle; Inverse back to right-facing.
    Player_Status = 4'd9;
    Inverse = 1'b0;
    do_tick(3'd0, 1'b0, "status9_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
